// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch port (I) and the load/store port (D).
// Define MEM_PORT_ARBITER_TIMEOUT_EN to abort transfers whose memory never completes.
module mem_port_arbiter #(
  parameter int IADDR_W   = 32,
  parameter int DADDR_W   = 32,
  parameter int DDATA_W   = 32,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IADDR_W-1:0] memIAddr,
  input  logic               reqI,
  output logic               memIReady,
  output logic [DDATA_W-1:0] memIData,
  input  logic [DADDR_W-1:0] memDAddr,
  input  logic [DDATA_W-1:0] memDData,
  input  logic               wr,
  input  logic               reqD,
  output logic               memDReady,
  output logic [DDATA_W-1:0] memDDataOut,
  output logic [ADDR_W-1:0]  memAddr,
  output logic               memWr,
  output logic               memReq,
  output logic [DDATA_W-1:0] memDataIn,
  input  logic [DDATA_W-1:0] memDataOut,
  input  logic               memBusyOut,
  output logic               memErr,
  output logic [1:0]         dbg_state
);

  // Handshake: memReq is held with stable address/data until memBusyOut=1 is sampled
  // (accept); the transfer completes when memBusyOut=0 is then sampled, and the
  // granted port sees a one-cycle ready pulse with its data output already updated.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic              grant_d;
  logic              last_grant_d;
  logic              pick_d;
  logic              err_q;
  logic              tmo_hit;
  logic [ADDR_W-1:0] i_addr;
  logic [ADDR_W-1:0] d_addr;

  assign i_addr    = ADDR_W'(memIAddr);
  assign d_addr    = ADDR_W'(memDAddr);
  assign dbg_state = state;
  assign memErr    = err_q;

  // On a tie the port that did not win last time is granted.
  assign pick_d = reqD && (!reqI || !last_grant_d);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  assign tmo_hit = &tmo_cnt;

  // Cleared while idle and on the accept edge, so it restarts on entry to ISSUE and WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || (state == ISSUE && memBusyOut)) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE || state == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      grant_d      <= 1'b0;
      last_grant_d <= 1'b1;
      memReq       <= 1'b0;
      memWr        <= 1'b0;
      memAddr      <= '0;
      memDataIn    <= '0;
      memIData     <= '0;
      memDDataOut  <= '0;
      memIReady    <= 1'b0;
      memDReady    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      memIReady <= 1'b0;
      memDReady <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        IDLE: begin
          // A busy memory left over from an aborted transfer blocks new grants.
          if (!memBusyOut && (reqI || reqD)) begin
            grant_d <= pick_d;
            memReq  <= 1'b1;
            state   <= ISSUE;
            if (pick_d) begin
              memAddr   <= d_addr;
              memWr     <= wr;
              memDataIn <= memDData;
            end else begin
              memAddr <= i_addr;
              memWr   <= 1'b0;
            end
          end
        end
        ISSUE: begin
          if (memBusyOut) begin
            memReq <= 1'b0;
            state  <= WAIT;
          end else if (tmo_hit) begin
            memReq       <= 1'b0;
            err_q        <= 1'b1;
            memIReady    <= !grant_d;
            memDReady    <= grant_d;
            last_grant_d <= grant_d;
            state        <= IDLE;
          end
        end
        WAIT: begin
          if (!memBusyOut) begin
            if (grant_d) begin
              if (!memWr) memDDataOut <= memDataOut;
              memDReady <= 1'b1;
            end else begin
              memIData  <= memDataOut;
              memIReady <= 1'b1;
            end
            last_grant_d <= grant_d;
            state        <= DONE;
          end else if (tmo_hit) begin
            err_q        <= 1'b1;
            memIReady    <= !grant_d;
            memDReady    <= grant_d;
            last_grant_d <= grant_d;
            state        <= IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
